// File: rtl/keccak_padder.sv
// rtl/keccak_padder.sv - streaming byte-to-rate-block assembler with FIPS 202 padding
module keccak_padder #(
  parameter int         D      = 256,
  parameter int         W      = 8,
  parameter logic [7:0] SUFFIX = 8'h06
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [8*W-1:0]             in_data,
  input  logic [$clog2(W+1)-1:0]     in_bytes,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1600-2*D-1:0]        out_block,
  output logic                       out_last
);

  localparam int R  = 1600 - 2 * D;
  localparam int RB = R / 8;
  localparam int PW = $clog2(RB);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    EMIT   = 2'd1,
    PADBLK = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          pend_q, pend_d;
  logic          last_q, last_d;
  logic [R-1:0]  blk_q, blk_d;

  // Beat decode: effective byte count, pointer as int, and where the tail lands.
  int            n_eff;
  int            ptr_i;
  logic          pad_here;
  logic          block_full;
  logic [R-1:0]  fill_blk;

  // Only a final beat may be short; oversize counts saturate at W.
  always_comb begin
    n_eff = W;
    if (in_last && (int'(in_bytes) < W)) begin
      n_eff = int'(in_bytes);
    end
    ptr_i      = int'(ptr_q);
    pad_here   = in_last && ((ptr_i + n_eff) < RB);
    block_full = (ptr_i + W) == RB;
  end

  // Merge the current beat into the buffer; a final beat that leaves room also lays down the padding.
  always_comb begin
    fill_blk = blk_q;
    for (int k = 0; k < RB; k++) begin
      for (int j = 0; j < W; j++) begin
        if (k == ptr_i + j) begin
          fill_blk[8*k +: 8] = (j < n_eff) ? in_data[8*j +: 8] : 8'h00;
        end
      end
      if (pad_here) begin
        if (k == ptr_i + n_eff) begin
          fill_blk[8*k +: 8] = SUFFIX;
        end else if (k > ptr_i + n_eff) begin
          fill_blk[8*k +: 8] = 8'h00;
        end
      end
    end
    // The closing pad bit shares the top byte with the suffix when the tail ends one byte short.
    if (pad_here) begin
      fill_blk[R-1 -: 8] = fill_blk[R-1 -: 8] | 8'h80;
    end
  end

  // Next-state, buffer update and handshake outputs.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    pend_d    = pend_q;
    last_d    = last_q;
    blk_d     = blk_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          blk_d = fill_blk;
          if (in_last) begin
            ptr_d   = '0;
            state_d = EMIT;
            if (pad_here) begin
              last_d = 1'b1;
            end else begin
              // Message ended exactly on a block boundary: padding needs a block of its own.
              last_d = 1'b0;
              pend_d = 1'b1;
            end
          end else if (block_full) begin
            ptr_d   = '0;
            last_d  = 1'b0;
            state_d = EMIT;
          end else begin
            ptr_d = ptr_q + PW'(W);
          end
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (pend_q) begin
            state_d = PADBLK;
          end else begin
            blk_d   = '0;
            last_d  = 1'b0;
            state_d = FILL;
          end
        end
      end
      PADBLK: begin
        blk_d          = '0;
        blk_d[7:0]     = SUFFIX;
        blk_d[R-1 -: 8] = 8'h80;
        last_d         = 1'b1;
        pend_d         = 1'b0;
        state_d        = EMIT;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and buffer registers; reset discards any partial block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      ptr_q   <= '0;
      pend_q  <= 1'b0;
      last_q  <= 1'b0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      blk_q   <= blk_d;
    end
  end

  assign out_block = blk_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_keccak_padder.sv
// tb/tb_keccak_padder.sv - scoreboard bench for keccak_padder (SHA3-256 and SHAKE instances in lockstep)
module tb_keccak_padder;

  localparam int D  = 256;
  localparam int W  = 8;
  localparam int R  = 1600 - 2 * D;
  localparam int RB = R / 8;
  localparam int BW = $clog2(W + 1);

  typedef byte unsigned bq_t[$];

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           in_valid = 1'b0;
  logic [8*W-1:0] in_data = '0;
  logic [BW-1:0]  in_bytes = '0;
  logic           in_last = 1'b0;
  logic           out_ready = 1'b0;

  logic           a_in_ready, a_out_valid, a_out_last;
  logic [R-1:0]   a_out_block;
  logic           b_in_ready, b_out_valid, b_out_last;
  logic [R-1:0]   b_out_block;

  int n_cmp = 0;
  int n_bad = 0;

  logic [R-1:0] exp_a[$];
  logic [R-1:0] exp_b[$];
  bit           expl_a[$];
  bit           expl_b[$];

  always #5 clk = ~clk;

  keccak_padder #(.D(D), .W(W), .SUFFIX(8'h06)) u_sha3 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .in_bytes(in_bytes), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_block(a_out_block), .out_last(a_out_last)
  );

  keccak_padder #(.D(D), .W(W), .SUFFIX(8'h1F)) u_shake (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .in_bytes(in_bytes), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_block(b_out_block), .out_last(b_out_last)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [R-1:0] got, input logic [R-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      for (int k = 0; k < RB; k++) begin
        if (got[8*k +: 8] !== exp[8*k +: 8]) begin
          $error("FAIL %s: byte %0d observed %02h expected %02h", tag, k, got[8*k +: 8], exp[8*k +: 8]);
          break;
        end
      end
    end
  endtask

  // Reference pad10*1: message, suffix, zeros, top bit of the last rate byte.
  task automatic push_exp(input bq_t msg);
    int len  = msg.size();
    int nblk = len / RB + 1;
    int tot  = nblk * RB;
    for (int b = 0; b < nblk; b++) begin
      logic [R-1:0] ba = '0;
      logic [R-1:0] bb = '0;
      for (int k = 0; k < RB; k++) begin
        int idx = b * RB + k;
        byte unsigned va = 8'h00;
        byte unsigned vb = 8'h00;
        if (idx < len) begin
          va = msg[idx];
          vb = msg[idx];
        end else if (idx == len) begin
          va = 8'h06;
          vb = 8'h1F;
        end
        if (idx == tot - 1) begin
          va = va | 8'h80;
          vb = vb | 8'h80;
        end
        ba[8*k +: 8] = va;
        bb[8*k +: 8] = vb;
      end
      exp_a.push_back(ba);
      exp_b.push_back(bb);
      expl_a.push_back(b == nblk - 1);
      expl_b.push_back(b == nblk - 1);
    end
  endtask

  task automatic recv_block(input int exp_lat, input string tag);
    int cyc = 0;
    logic [R-1:0] ea, eb;
    bit la, lb;
    out_ready = 1'b1;
    while (!a_out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_valid"}, 64'(a_out_valid), 64'd1);
    if (exp_lat >= 0) chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_sb_nonempty"}, 64'(exp_a.size() > 0), 64'd1);
    if (exp_a.size() > 0) begin
      ea = exp_a.pop_front();
      eb = exp_b.pop_front();
      la = expl_a.pop_front();
      lb = expl_b.pop_front();
      chk_blk({tag, "_sha3_blk"}, a_out_block, ea);
      chk({tag, "_sha3_last"}, 64'(a_out_last), 64'(la));
      chk_blk({tag, "_shake_blk"}, b_out_block, eb);
      chk({tag, "_shake_last"}, 64'(b_out_last), 64'(lb));
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(a_out_valid), 64'd0);
  endtask

  task automatic send_beat(input logic [63:0] data, input int nb, input bit last, input string tag);
    int cyc = 0;
    in_valid = 1'b1;
    in_data  = data;
    in_bytes = BW'(nb);
    in_last  = last;
    while (!a_in_ready && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 200) chk({tag, "_in_ready_timeout"}, 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_msg(input bq_t msg, input bit bp, input bit oversize, input string tag);
    logic [63:0] bd[$];
    int          bn[$];
    bit          bl[$];
    int          len = msg.size();
    int          cnt = 0;
    push_exp(msg);
    if (len == 0) begin
      bd.push_back({$urandom, $urandom});
      bn.push_back(0);
      bl.push_back(1'b1);
    end else begin
      for (int p = 0; p < len; p += W) begin
        logic [63:0] d = {$urandom, $urandom};
        int  rem = len - p;
        int  n   = (rem < W) ? rem : W;
        bit  lst = (p + W) >= len;
        for (int j = 0; j < n; j++) d[8*j +: 8] = msg[p + j];
        bd.push_back(d);
        bl.push_back(lst);
        if (!lst) bn.push_back(int'($urandom_range(0, 15)));
        else if (oversize && n == W) bn.push_back(12);
        else bn.push_back(n);
      end
    end
    for (int i = 0; i < bd.size(); i++) begin
      send_beat(bd[i], bn[i], bl[i], tag);
      if (bl[i]) begin
        int g = 0;
        while (exp_a.size() > 0 && g < 4) begin
          recv_block((g == 0) ? 0 : 1, tag);
          g++;
        end
      end else begin
        cnt += W;
        if (cnt % RB == 0) begin
          if (bp) begin
            in_valid = 1'b1;
            in_data  = bd[i+1];
            in_bytes = BW'(bn[i+1]);
            in_last  = bl[i+1];
            for (int c = 0; c < 5; c++) begin
              chk({tag, "_bp_in_ready"}, 64'(a_in_ready), 64'd0);
              chk({tag, "_bp_out_valid"}, 64'(a_out_valid), 64'd1);
              chk_blk({tag, "_bp_hold"}, a_out_block, exp_a[0]);
              @(posedge clk); #1;
            end
          end
          recv_block(bp ? -1 : 0, tag);
        end
      end
    end
  endtask

  function automatic bq_t rand_msg(input int len);
    bq_t m;
    for (int i = 0; i < len; i++) m.push_back(byte'($urandom_range(0, 255)));
    return m;
  endfunction

  initial begin
    bq_t m;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_last", 64'(a_out_last), 64'd0);
    chk_blk("rst_out_block", a_out_block, '0);
    chk("rst_shake_out_valid", 64'(b_out_valid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    m = {};
    send_msg(m, 1'b0, 1'b0, "empty");
    m = {8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0, 1'b0, "abc");
    send_msg(rand_msg(135), 1'b0, 1'b0, "len135");
    send_msg(rand_msg(136), 1'b0, 1'b0, "len136");
    send_msg(rand_msg(150), 1'b1, 1'b0, "bp150");
    send_msg(rand_msg(8), 1'b0, 1'b1, "len8_oversize");
    send_msg(rand_msg(300), 1'b0, 1'b0, "len300");
    send_msg(rand_msg(272), 1'b0, 1'b1, "len272_oversize");

    // Abort mid-fill: five beats, then reset
    for (int i = 0; i < 5; i++) send_beat({$urandom, $urandom}, W, 1'b0, "abort_fill");
    #2 reset = 1'b0;
    #1;
    chk("abort_fill_in_ready", 64'(a_in_ready), 64'd1);
    chk("abort_fill_out_valid", 64'(a_out_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_fill_post_valid", 64'(a_out_valid), 64'd0);
    chk_blk("abort_fill_post_blk", b_out_block, '0);

    // Abort mid-emit: a full block waiting with out_ready low
    for (int i = 0; i < RB / W; i++) send_beat({$urandom, $urandom}, W, 1'b0, "abort_emit");
    chk("abort_emit_valid_before", 64'(a_out_valid), 64'd1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("abort_emit_valid", 64'(a_out_valid), 64'd0);
    chk("abort_emit_shake_last", 64'(b_out_last), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_emit_post_valid", 64'(b_out_valid), 64'd0);

    m = {8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0, 1'b0, "abc_after_reset");

    chk("sb_drained", 64'(exp_a.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
